ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: max cycles in WAIT or DROP without a response; 0 disables the timeout.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pc  in  64  current fetch address from the PC register.
REQ-005 jump_exe  in  1  redirect from EX; squashes the fetch in flight.
REQ-006 id_stall  in  1  IF/ID cannot accept an instruction this cycle.
REQ-007 pc_stall  out  1  PC register hold; PC loads npc when 0.
REQ-008 mem_req_valid  out  1  fetch request valid.
REQ-009 mem_req_addr  out  64  fetch address.
REQ-010 mem_req_ready  in  1  memory accepts the request.
REQ-011 mem_resp_valid  in  1  fetch data valid.
REQ-012 mem_resp_data  in  32  fetched instruction.
REQ-013 inst_valid  out  1  inst/inst_pc valid toward IF/ID.
REQ-014 inst  out  32  instruction.
REQ-015 inst_pc  out  64  address of inst.
REQ-016 fetch_err  out  1  one-cycle timeout pulse.
REQ-017 inst_misalign  out  1  misaligned-fetch flag qualified by inst_valid.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD, DROP; all outputs registered except pc_stall.
REQ-019 IDLE (1 cycle): req_pc <= pc, next REQ; if jump_exe, stay IDLE (reload from new pc next cycle).
REQ-020 REQ: mem_req_valid=1, mem_req_addr=req_pc, both held stable until mem_req_valid&&mem_req_ready at an edge; then WAIT.
REQ-021 REQ with jump_exe: request never withdrawn; drop_pend set; on handshake go DROP instead of WAIT (also if handshake and jump_exe coincide).
REQ-022 WAIT: on mem_resp_valid, inst<=mem_resp_data, inst_pc<=req_pc, next HOLD; mem_resp_valid outside WAIT/DROP ignored.
REQ-023 WAIT with jump_exe: no response -> DROP; response same cycle -> response discarded, next IDLE.
REQ-024 HOLD: inst_valid=1; id_stall=1 -> stay HOLD, outputs stable; id_stall=0 -> instruction consumed, next IDLE.
REQ-025 HOLD with jump_exe: instruction discarded, inst_valid=0 next cycle, next IDLE.
REQ-026 DROP: on mem_resp_valid, discard, next IDLE; jump_exe in DROP keeps DROP.
REQ-027 pc_stall = NOT(jump_exe OR (state==HOLD AND NOT id_stall)); combinational.
REQ-028 Timeout counter cleared on entry to WAIT/DROP, increments each cycle there; reaching TIMEOUT_CYC with no response: fetch_err=1 for one cycle, next IDLE (retry at current pc); late response then ignored.
REQ-029 Throughput: one instruction per 4 cycles minimum (IDLE, REQ, WAIT, HOLD) with zero-wait memory.

Reset
REQ-030 rst=1 at an edge: state=IDLE, mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, req_pc=0, fetch_err=0, inst_misalign=0, drop_pend=0, counter=0.
REQ-031 Reset mid-transaction abandons it; a response arriving after reset before the first REQ is ignored.

Configuration
REQ-032 Macro IFETCH_MISALIGN_CHK_EN defined: in IDLE, pc[1:0]!=0 issues no request; next HOLD with inst=32'h00000013, inst_pc=pc, inst_misalign=1.
REQ-033 Macro undefined: no alignment check, unaligned addresses issued as-is, inst_misalign tied 0; port list unchanged.

Verification
REQ-034 Reset, pc=0x1000, ready=1, response 1 cycle after handshake data 0x00500093 -> addr 0x1000, inst_valid with inst=0x00500093, inst_pc=0x1000, pc_stall=0 one cycle.
REQ-035 mem_req_ready low 3 cycles -> mem_req_valid high and mem_req_addr constant for 4 cycles; single handshake.
REQ-036 jump_exe in WAIT, response 2 cycles later -> response discarded, inst_valid stays 0, next request uses redirected pc 0x2000.
REQ-037 id_stall=1 for 5 cycles in HOLD -> inst/inst_pc stable, pc_stall=1; release -> pc_stall=0 one cycle, new request follows.
REQ-038 TIMEOUT_CYC=4, no response -> fetch_err pulses 4 cycles after WAIT entry, request reissued at same pc.
REQ-039 With IFETCH_MISALIGN_CHK_EN, pc=0x1002 -> no mem_req_valid, inst=0x00000013, inst_misalign=1.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if -- instruction memory request/response bus.
// master = fetch unit side, slave = instruction memory side.
interface ifetch_unit_if;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit -- single-outstanding instruction fetch FSM with redirect squash and timeout.
// Optional misaligned-fetch trap enabled by defining IFETCH_MISALIGN_CHK_EN.
module ifetch_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   pc,
    input  logic          jump_exe,
    input  logic          id_stall,
    output logic          pc_stall,
    ifetch_unit_if.master mem,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [63:0]   inst_pc,
    output logic          fetch_err,
    output logic          inst_misalign
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t        state_q, state_d;
    logic [63:0]   req_pc_q, req_pc_d;
    logic [31:0]   inst_q, inst_d;
    logic [63:0]   ipc_q, ipc_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          mis_q, mis_d;
    logic          req_v_q;
    logic          ival_q;
    logic          hs;
    logic          tmo;
    logic          misal;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign misal = (pc[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign hs  = req_v_q && mem.mem_req_ready;
    assign tmo = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    assign pc_stall = !(jump_exe || ((state_q == S_HOLD) && !id_stall));

    assign mem.mem_req_valid = req_v_q;
    assign mem.mem_req_addr  = req_pc_q;
    assign inst_valid        = ival_q;
    assign inst              = inst_q;
    assign inst_pc           = ipc_q;
    assign fetch_err         = err_q;
    assign inst_misalign     = mis_q;

    // Next-state and registered-output values for the fetch sequence
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        inst_d   = inst_q;
        ipc_d    = ipc_q;
        drop_d   = drop_q;
        cnt_d    = '0;
        err_d    = 1'b0;
        mis_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_pc_d = pc;
                drop_d   = 1'b0;
                if (!jump_exe) begin
                    if (misal) begin
                        state_d = S_HOLD;
                        inst_d  = NOP;
                        ipc_d   = pc;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (hs) begin
                    state_d = (drop_q || jump_exe) ? S_DROP : S_WAIT;
                    drop_d  = 1'b0;
                end else if (jump_exe) begin
                    drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem.mem_resp_valid) begin
                    if (jump_exe) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                        inst_d  = mem.mem_resp_data;
                        ipc_d   = req_pc_q;
                    end
                end else if (jump_exe) begin
                    state_d = S_DROP;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_HOLD: begin
                mis_d = mis_q;
                if (jump_exe || !id_stall) begin
                    state_d = S_IDLE;
                    mis_d   = 1'b0;
                end
            end
            S_DROP: begin
                cnt_d = cnt_q + CW'(1);
                if (mem.mem_resp_valid) begin
                    state_d = S_IDLE;
                end else if (tmo) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; valid flags follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_pc_q <= '0;
            inst_q   <= '0;
            ipc_q    <= '0;
            drop_q   <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
            req_v_q  <= 1'b0;
            ival_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            inst_q   <= inst_d;
            ipc_q    <= ipc_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            mis_q    <= mis_d;
            req_v_q  <= (state_d == S_REQ);
            ival_q   <= (state_d == S_HOLD);
        end
    end
endmodule
